// File: rtl/uart_tx.sv
// uart_tx: UART transmitter with start bit, 8 data bits (LSB first), optional parity and 1 or 2 stop bits
module uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in,
  input  logic       valid_in,
  output logic       ready_in,
  input  logic       c_valid,
  input  logic [3:0] c_addr,
  input  logic [7:0] c_data,
  output logic       c_ready,
  output logic       out,
  output logic       busy,
  output logic       done
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam logic [11:0] RELOAD = 12'(CLKS_PER_BIT - 1);
  state_t state, nxt;
  logic [11:0] cnt;
  logic [2:0] idx;
  logic [7:0] data;
  logic par_bit, par_en, two_stop, cfg_stop2;
  logic [1:0] cfg_par, eff_par;
  logic eff_stop2, tick, acc, cfg_wr;
  assign tick = cnt == 12'd0;
  assign acc = valid_in && ready_in;
  assign cfg_wr = c_valid && c_ready;
  // a config write in the accepting cycle must shape the frame being accepted
  assign eff_par = (cfg_wr && c_addr == 4'b0101) ? c_data[1:0] : cfg_par;
  assign eff_stop2 = (cfg_wr && c_addr == 4'b0110) ? c_data[0] : cfg_stop2;
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= nxt;
  end
  // next-state logic
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = acc ? START : IDLE;
      START:   nxt = tick ? DATA : START;
      DATA:    nxt = (tick && idx == 3'd7) ? (par_en ? PARITY : STOP) : DATA;
      PARITY:  nxt = tick ? STOP : PARITY;
      STOP:    nxt = (tick && idx == {2'b00, two_stop}) ? IDLE : STOP;
      default: nxt = IDLE;
    endcase
  end
  // outputs decoded from the current state
  always_comb begin
    out = state == START ? 1'b0 : state == DATA ? data[idx] : state == PARITY ? par_bit : 1'b1;
    busy = state != IDLE;
    ready_in = state == IDLE && !rst;
    c_ready = state == IDLE && !rst;
  end
  // bit timer and bit index; index restarts at every state change
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= RELOAD;
      idx <= 3'd0;
      done <= 1'b0;
    end else begin
      cnt <= (state == IDLE || tick) ? RELOAD : cnt - 12'd1;
      idx <= (state != nxt) ? 3'd0 : tick ? idx + 3'd1 : idx;
      done <= state == STOP && nxt == IDLE;
    end
  end
  // latch byte and freeze frame format on acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      data <= 8'd0;
      par_bit <= 1'b0;
      par_en <= 1'b0;
      two_stop <= 1'b0;
    end else if (acc) begin
      data <= in;
      par_bit <= (^in) ^ (eff_par == 2'b10);
      par_en <= eff_par == 2'b01 || eff_par == 2'b10;
      two_stop <= eff_stop2;
    end
  end
  // configuration registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_par <= 2'b00;
      cfg_stop2 <= 1'b0;
    end else if (cfg_wr) begin
      if (c_addr == 4'b0101) cfg_par <= c_data[1:0];
      if (c_addr == 4'b0110) cfg_stop2 <= c_data[0];
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed and randomized checks of uart_tx against a frame-level bit list model
module tb_uart_tx;
  localparam int CPB = 16;
  logic clk = 0, rst = 1;
  logic [7:0] in = 0, c_data = 0;
  logic valid_in = 0, c_valid = 0;
  logic [3:0] c_addr = 0;
  logic ready_in, c_ready, out, busy, done;
  int tests = 0, failed = 0;
  int cur_pm = 0;
  bit cur_s2 = 0;
  int w;
  uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .in(in), .valid_in(valid_in), .ready_in(ready_in),
    .c_valid(c_valid), .c_addr(c_addr), .c_data(c_data), .c_ready(c_ready),
    .out(out), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cfg(input logic [3:0] a, input logic [7:0] d);
    c_valid = 1; c_addr = a; c_data = d;
    chk("cfg_cready_idle", c_ready, 1);
    tick();
    c_valid = 0;
    if (a == 4'b0101) cur_pm = int'(d[1:0]);
    if (a == 4'b0110) cur_s2 = d[0];
  endtask
  // frame model: start 0, data LSB first, parity if enabled, stop bit(s); each bit CPB cycles
  task automatic send(input logic [7:0] b, input bit keep, input logic [7:0] nb, output int waited);
    logic bits[$];
    int len;
    in = b; valid_in = 1; waited = 0;
    while (!ready_in && waited < 1000) begin
      tick();
      waited++;
    end
    chk("accept_ready", ready_in, 1);
    bits = {};
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
    if (cur_pm == 1) bits.push_back(^b);
    if (cur_pm == 2) bits.push_back(~^b);
    bits.push_back(1'b1);
    if (cur_s2) bits.push_back(1'b1);
    len = bits.size() * CPB;
    tick();
    if (keep) in = nb; else valid_in = 0;
    for (int k = 0; k < len; k++) begin
      chk("out_bit", out, bits[k / CPB]);
      chk("busy_frame", busy, 1);
      chk("ready_frame", ready_in, 0);
      chk("done_early", done, 0);
      tick();
    end
    chk("done_pulse", done, 1);
    chk("busy_end", busy, 0);
    chk("out_end", out, 1);
    chk("ready_end", ready_in, 1);
  endtask
  initial begin
    logic [7:0] rb;
    repeat (3) tick();
    chk("rst_ready", ready_in, 0);
    chk("rst_cready", c_ready, 0);
    chk("rst_out", out, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 0;
    tick();
    for (int i = 0; i < 1000; i++) begin
      chk("idle_out", out, 1);
      chk("idle_ready", ready_in, 1);
      chk("idle_cready", c_ready, 1);
      chk("idle_busy", busy, 0);
      tick();
    end
    send(8'hA5, 0, 8'h00, w);
    tick();
    cfg(4'b0101, 8'h01);
    cfg(4'b0110, 8'h01);
    send(8'h07, 0, 8'h00, w);
    tick();
    cfg(4'b0101, 8'h02);
    send(8'h07, 0, 8'h00, w);
    tick();
    fork
      send(8'h3C, 0, 8'h00, w);
      begin
        repeat (50) tick();
        c_valid = 1; c_addr = 4'b0101; c_data = 8'h00;
        chk("cfg_midframe_cready", c_ready, 0);
        tick();
        c_valid = 0;
      end
    join
    tick();
    send(8'h3C, 0, 8'h00, w);
    tick();
    send(8'h00, 1, 8'hFF, w);
    send(8'hFF, 0, 8'h00, w);
    chk("b2b_no_wait", w, 0);
    tick();
    rb = 8'($urandom);
    in = rb; valid_in = 1;
    tick();
    valid_in = 0;
    repeat (70) tick();
    chk("mid_data3", out, rb[3]);
    rst = 1;
    tick();
    chk("abort_out", out, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_ready", ready_in, 0);
    cur_pm = 0; cur_s2 = 0;
    rst = 0;
    tick();
    chk("post_rst_ready", ready_in, 1);
    send(8'($urandom), 0, 8'h00, w);
    for (int n = 0; n < 8; n++) begin
      tick();
      cfg(4'b0101, 8'($urandom_range(0, 3)));
      cfg(4'b0110, 8'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) cfg(4'h3, 8'($urandom));
      send(8'($urandom), 0, 8'h00, w);
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
